// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two combinational read ports, one write port, r0 hardwired to zero
module register_file (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic [0:31] reg_data,
  input  logic [0:4]  register_no,
  input  logic [0:4]  readReg1,
  input  logic [0:4]  readReg2,
  output logic [0:31] readData1,
  output logic [0:31] readData2
);

  logic [0:31] regs_q [0:31];
  logic [0:31] regs_d [0:31];

  // Writes to r0 are dropped here so r0 never leaves its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (write && (register_no != 5'd0)) begin
      regs_d[register_no] = reg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign readData1 = regs_q[readReg1];
  assign readData2 = regs_q[readReg2];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file against an array model
module tb_register_file;

  logic        clk;
  logic        reset_n;
  logic        write;
  logic [0:31] reg_data;
  logic [0:4]  register_no;
  logic [0:4]  readReg1;
  logic [0:4]  readReg2;
  logic [0:31] readData1;
  logic [0:31] readData2;

  logic [31:0] model [32];
  int n_checks;
  int n_pass;

  register_file dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .write       (write),
    .reg_data    (reg_data),
    .register_no (register_no),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .readData1   (readData1),
    .readData2   (readData2)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Apply one clock edge and advance the model by the architectural write rule.
  task automatic clock_edge();
    @(posedge clk);
    if (reset_n && write && register_no != 5'd0) model[register_no] = reg_data;
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      check({tag, "_p1"}, readData1, model[i]);
      check({tag, "_p2"}, readData2, model[31 - i]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n = 1'b0; write = 1'b0; reg_data = '0; register_no = '0;
    readReg1 = '0; readReg2 = '0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    check("reset_r0", readData1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // basic write to r1
    write = 1'b1; register_no = 5'd1; reg_data = 32'h39CE739E;
    clock_edge();
    write = 1'b0; readReg1 = 5'd0; readReg2 = 5'd1; #1;
    check("basic_r0", readData1, 32'h00000000);
    check("basic_r1", readData2, 32'h39CE739E);

    // r0 protection
    write = 1'b1; register_no = 5'd0; reg_data = 32'h39CE7F9E;
    clock_edge();
    write = 1'b0; #1;
    check("r0_prot", readData1, 32'h00000000);
    check("r0_prot_r1", readData2, 32'h39CE739E);

    // write disabled
    register_no = 5'd1; reg_data = 32'hFFFFFFFF;
    repeat (3) clock_edge();
    check("wr_dis_r1", readData2, 32'h39CE739E);

    // read during write: old before edge, new after
    write = 1'b1; register_no = 5'd1; reg_data = 32'hC0000000; readReg2 = 5'd1; #1;
    check("rdw_pre", readData2, 32'h39CE739E);
    clock_edge();
    check("rdw_post", readData2, 32'hC0000000);
    write = 1'b0;

    // full sweep
    for (int i = 1; i < 32; i++) begin
      write = 1'b1; register_no = 5'(i); reg_data = 32'hA5A50000 + 32'(i);
      clock_edge();
    end
    write = 1'b0;
    check("sweep_r31_const", model[31], 32'hA5A5001F);
    check_all("sweep");

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      write       = 1'($urandom_range(0, 1));
      register_no = 5'($urandom_range(0, 31));
      reg_data    = $urandom;
      readReg1    = 5'($urandom_range(0, 31));
      readReg2    = ($urandom_range(0, 3) == 0) ? register_no : 5'($urandom_range(0, 31));
      #1;
      check("rnd_pre1", readData1, model[readReg1]);
      check("rnd_pre2", readData2, model[readReg2]);
      clock_edge();
      check("rnd_post1", readData1, model[readReg1]);
      check("rnd_post2", readData2, model[readReg2]);
    end

    // mid-cycle reset with a pending write: clears immediately, write never lands
    @(negedge clk); #1;
    write = 1'b1; register_no = 5'd5; reg_data = 32'hDEADBEEF;
    reset_n = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i); readReg2 = 5'(31 - i); #1;
      check("async_rst1", readData1, 32'h0);
      check("async_rst2", readData2, 32'h0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b1; write = 1'b0; #1;
    check_all("post_rst");

    // first write after reset release takes effect at the first edge
    write = 1'b1; register_no = 5'd7; reg_data = 32'h12345678;
    clock_edge();
    write = 1'b0; readReg1 = 5'd7; #1;
    check("first_wr", readData1, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
